// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 16x2 character LCD driver on an 8-bit write-only bus.
// Define LCD_ICID_EN to add ic_id, shown as hex in row 1 cols 14..15 for codes 3/4/6.
module lcd_ctrl #(
    parameter int PWR_CYC = 750000,
    parameter int EN_CYC  = 12,
    parameter int CMD_CYC = 2000,
    parameter int CLR_CYC = 82000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] LCD_STATE,
`ifdef LCD_ICID_EN
    input  logic [7:0] ic_id,
`endif
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       busy
);

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, CLEAR, LINE1, LINE2} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

    // Delay loads are one less than the cycle count: the counter runs down to 0
    localparam logic [19:0] PWR_LD = 20'(PWR_CYC - 1);
    localparam logic [19:0] EN_LD  = 20'(EN_CYC - 1);
    localparam logic [19:0] CMD_LD = 20'(CMD_CYC - 1);
    localparam logic [19:0] CLR_LD = 20'(CLR_CYC - 1);

    function automatic logic [127:0] pad16(input logic [127:0] s, input int n);
        logic [127:0] r;
        r = s << (8 * (16 - n));
        for (int i = 0; i < 16 - n; i++) r[8*i +: 8] = 8'h20;
        return r;
    endfunction

    localparam logic [127:0] S_READY  = pad16(128'("READY"), 5);
    localparam logic [127:0] S_INSERT = pad16(128'("INSERT IC"), 9);
    localparam logic [127:0] S_TEST   = pad16(128'("TESTING..."), 10);
    localparam logic [127:0] S_WAIT   = pad16(128'("PLEASE WAIT"), 11);
    localparam logic [127:0] S_RESULT = pad16(128'("RESULT:"), 7);
    localparam logic [127:0] S_PASS   = pad16(128'("PASS"), 4);
    localparam logic [127:0] S_FAIL   = pad16(128'("FAIL"), 4);
    localparam logic [127:0] S_INVAL  = pad16(128'("INVALID IC"), 10);
    localparam logic [127:0] S_CHECK  = pad16(128'("CHECK PART"), 10);
    localparam logic [127:0] S_ERROR  = pad16(128'("ERROR"), 5);
    localparam logic [127:0] S_CODE   = pad16(128'("CODE"), 4);

    function automatic logic [7:0] hex_char(input logic [3:0] d);
        return (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h37 + {4'h0, d};
    endfunction

    // Character ROM: first character of a row sits in the top byte
    function automatic logic [7:0] rom_char(input logic [3:0] c,
                                            input logic row,
                                            input logic [3:0] i);
        logic [127:0] s;
        logic [127:0] sh;
        logic         err;
        err = 1'b0;
        case (c)
            4'd1:       s = row ? S_INSERT : S_READY;
            4'd2, 4'd5: s = row ? S_WAIT : S_TEST;
            4'd3:       s = row ? S_PASS : S_RESULT;
            4'd4:       s = row ? S_FAIL : S_RESULT;
            4'd6:       s = row ? S_CHECK : S_INVAL;
            default: begin
                s   = row ? S_CODE : S_ERROR;
                err = 1'b1;
            end
        endcase
        sh = s >> {4'd15 - i, 3'b000};
        if (err && row && i == 4'd5) return hex_char(c);
        return sh[7:0];
    endfunction

    state_t      st, nxt_st;
    phase_t      ph;
    logic [19:0] dly;
    logic [1:0]  init_idx, nxt_init;
    logic        addr_sent, nxt_addr;
    logic [3:0]  idx, nxt_idx;
    logic [3:0]  code, state_q;
    logic        pending;
    logic        start, redraw, in_chg, hold_done, is_clr;
    logic        nxt_rs;
    logic [7:0]  nxt_data;
`ifdef LCD_ICID_EN
    logic [7:0]  id, id_q;
`endif

    assign LCD_RW    = 1'b0;
    assign hold_done = (ph == HOLD) && (dly == 20'd0);
    assign is_clr    = !LCD_RS && (LCD_DATA == 8'h01 || LCD_DATA == 8'h02);
`ifdef LCD_ICID_EN
    assign redraw = (LCD_STATE != code) || (ic_id != id);
    assign in_chg = (LCD_STATE != state_q) || (ic_id != id_q);
`else
    assign redraw = (LCD_STATE != code);
    assign in_chg = (LCD_STATE != state_q);
`endif

    // Byte sequencer: where the next byte comes from once the current one is done
    always_comb begin
        nxt_st   = st;
        nxt_init = init_idx;
        nxt_addr = addr_sent;
        nxt_idx  = idx;
        start    = 1'b0;
        unique case (st)
            PWR_WAIT: if (dly == 20'd0) begin
                nxt_st   = INIT;
                nxt_init = 2'd0;
                start    = 1'b1;
            end
            INIT: if (hold_done) begin
                if (init_idx == 2'd3) nxt_st = IDLE;
                else begin
                    nxt_init = init_idx + 2'd1;
                    start    = 1'b1;
                end
            end
            IDLE: if (redraw) begin
                nxt_st = CLEAR;
                start  = 1'b1;
            end
            CLEAR: if (hold_done) begin
                nxt_st   = LINE1;
                nxt_addr = 1'b0;
                nxt_idx  = 4'd0;
                start    = 1'b1;
            end
            LINE1, LINE2: if (hold_done) begin
                if (!addr_sent) begin
                    nxt_addr = 1'b1;
                    nxt_idx  = 4'd0;
                    start    = 1'b1;
                end else if (idx == 4'd15) begin
                    nxt_addr = 1'b0;
                    nxt_idx  = 4'd0;
                    if (st == LINE1) begin
                        nxt_st = LINE2;
                        start  = 1'b1;
                    end else begin
                        nxt_st = IDLE;
                    end
                end else begin
                    nxt_idx = idx + 4'd1;
                    start   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Byte value for the sequencer's next position
    always_comb begin
        nxt_rs   = 1'b0;
        nxt_data = 8'h00;
        unique case (nxt_st)
            INIT: begin
                case (nxt_init)
                    2'd0:    nxt_data = 8'h38;
                    2'd1:    nxt_data = 8'h0C;
                    2'd2:    nxt_data = 8'h06;
                    default: nxt_data = 8'h01;
                endcase
            end
            CLEAR: nxt_data = 8'h01;
            LINE1: begin
                if (nxt_addr) begin
                    nxt_rs   = 1'b1;
                    nxt_data = rom_char(code, 1'b0, nxt_idx);
                end else begin
                    nxt_data = 8'h80;
                end
            end
            LINE2: begin
                if (nxt_addr) begin
                    nxt_rs   = 1'b1;
                    nxt_data = rom_char(code, 1'b1, nxt_idx);
`ifdef LCD_ICID_EN
                    if (code == 4'd3 || code == 4'd4 || code == 4'd6) begin
                        if (nxt_idx == 4'd14) nxt_data = hex_char(id[7:4]);
                        if (nxt_idx == 4'd15) nxt_data = hex_char(id[3:0]);
                    end
`endif
                end else begin
                    nxt_data = 8'hC0;
                end
            end
            default: ;
        endcase
    end

    // Main FSM, byte strobe timing and registered bus outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= PWR_WAIT;
            ph        <= HOLD;
            dly       <= PWR_LD;
            init_idx  <= 2'd0;
            addr_sent <= 1'b0;
            idx       <= 4'd0;
            code      <= 4'h0;
            state_q   <= 4'h0;
            pending   <= 1'b0;
            LCD_DATA  <= 8'h00;
            LCD_RS    <= 1'b0;
            LCD_EN    <= 1'b0;
            busy      <= 1'b1;
`ifdef LCD_ICID_EN
            id        <= 8'h00;
            id_q      <= 8'h00;
`endif
        end else begin
            st        <= nxt_st;
            init_idx  <= nxt_init;
            addr_sent <= nxt_addr;
            idx       <= nxt_idx;
            state_q   <= LCD_STATE;
`ifdef LCD_ICID_EN
            id_q      <= ic_id;
`endif
            if (st == IDLE) begin
                busy <= redraw;
                if (redraw) begin
                    code <= LCD_STATE;
`ifdef LCD_ICID_EN
                    id   <= ic_id;
`endif
                end
            end
            if (st != IDLE && nxt_st == IDLE) begin
                if (pending) pending <= 1'b0;
            end else if (busy && in_chg) begin
                pending <= 1'b1;
            end
            if (start) begin
                ph       <= SETUP;
                LCD_DATA <= nxt_data;
                LCD_RS   <= nxt_rs;
            end else begin
                case (ph)
                    SETUP: begin
                        LCD_EN <= 1'b1;
                        ph     <= PULSE;
                        dly    <= EN_LD;
                    end
                    PULSE: begin
                        if (dly == 20'd0) begin
                            LCD_EN <= 1'b0;
                            ph     <= HOLD;
                            dly    <= is_clr ? CLR_LD : CMD_LD;
                        end else begin
                            dly <= dly - 20'd1;
                        end
                    end
                    default: if (dly != 20'd0) dly <= dly - 20'd1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed bench for lcd_ctrl with shortened timing.
// Captures every EN-strobed byte and compares it with hand-built expectations.
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] LCD_STATE;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       busy;
`ifdef LCD_ICID_EN
    logic [7:0] ic_id = 8'h00;
`endif

    int errors = 0;
    int checks = 0;

    logic [8:0] got[$];
    logic [8:0] exp[$];
    int         widths[$];
    logic       en_q = 1'b0;
    int         en_w = 0;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .PWR_CYC(20),
        .EN_CYC (2),
        .CMD_CYC(5),
        .CLR_CYC(10)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .LCD_STATE(LCD_STATE),
`ifdef LCD_ICID_EN
        .ic_id    (ic_id),
`endif
        .LCD_DATA (LCD_DATA),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .LCD_EN   (LCD_EN),
        .busy     (busy)
    );

    // Bus monitor: record byte at each EN rise and EN high width at each fall
    always @(negedge clk) begin
        if (LCD_EN && !en_q) got.push_back({LCD_RS, LCD_DATA});
        if (LCD_EN) en_w <= en_q ? en_w + 1 : 1;
        else if (en_q) widths.push_back(en_w);
        en_q <= LCD_EN;
    end

    task automatic clear_caps();
        got.delete();
        widths.delete();
        exp.delete();
    endtask

    task automatic exp_cmd(input logic [7:0] b);
        exp.push_back({1'b0, b});
    endtask

    task automatic exp_row(input string s, input logic [3:0] c, input bit row1);
        string hx = "0123456789ABCDEF";
        logic [7:0] ch;
        for (int i = 0; i < 16; i++) begin
            ch = (i < s.len()) ? 8'(s[i]) : 8'h20;
`ifdef LCD_ICID_EN
            if (row1 && (c == 4'd3 || c == 4'd4 || c == 4'd6)) begin
                if (i == 14) ch = 8'(hx[ic_id[7:4]]);
                if (i == 15) ch = 8'(hx[ic_id[3:0]]);
            end
`else
            if (row1 && c == 4'hF && hx.len() == 0) ch = 8'h00;
`endif
            exp.push_back({1'b1, ch});
        end
    endtask

    task automatic exp_draw(input logic [3:0] c, input string r0, input string r1);
        exp_cmd(8'h01);
        exp_cmd(8'h80);
        exp_row(r0, c, 1'b0);
        exp_cmd(8'hC0);
        exp_row(r1, c, 1'b1);
    endtask

    function automatic int first_diff();
        int n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp[i]) return i;
        if (got.size() != exp.size()) return n;
        return -1;
    endfunction

    function automatic int bad_widths();
        int b = 0;
        foreach (widths[i]) if (widths[i] != 2) b++;
        return b;
    endfunction

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        LCD_STATE = 4'd1;
        repeat (3) @(negedge clk);
        checks++;
        if (LCD_DATA !== 8'h00) begin
            errors++;
            $display("FAIL rst_data: got %h expected 00", LCD_DATA);
        end
        checks++;
        if (LCD_RS !== 1'b0) begin
            errors++;
            $display("FAIL rst_rs: got %b expected 0", LCD_RS);
        end
        checks++;
        if (LCD_RW !== 1'b0) begin
            errors++;
            $display("FAIL rst_rw: got %b expected 0", LCD_RW);
        end
        checks++;
        if (LCD_EN !== 1'b0) begin
            errors++;
            $display("FAIL rst_en: got %b expected 0", LCD_EN);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy: got %b expected 1", busy);
        end
    endtask

    task automatic test_init(input string tag);
        int early = 0;
        int d;
        bit ok;
        #2;
        clear_caps();
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (LCD_EN) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL %s_early_en: got %0d EN cycles expected 0", tag, early);
        end
        exp_cmd(8'h38);
        exp_cmd(8'h0C);
        exp_cmd(8'h06);
        exp_cmd(8'h01);
        exp_draw(4'd1, "READY", "INSERT IC");
        wait_idle(1000, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: busy got 1 expected 0 within 1000 cycles", tag);
        end
        d = first_diff();
        checks++;
        if (d !== -1) begin
            errors++;
            $display("FAIL %s_bytes: at %0d got %h expected %h (count %0d vs %0d)",
                     tag, d, got[d], exp[d], got.size(), exp.size());
        end
        checks++;
        if (bad_widths() !== 0 || widths.size() !== 39) begin
            errors++;
            $display("FAIL %s_en_width: got %0d bad of %0d pulses expected 0 of 39",
                     tag, bad_widths(), widths.size());
        end
    endtask

    task automatic test_redraw_fail();
        int d;
        bit ok;
        @(negedge clk);
        clear_caps();
        LCD_STATE = 4'd4;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: got %b expected 1", busy);
        end
        exp_draw(4'd4, "RESULT:", "FAIL");
        wait_idle(1000, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL fail_idle: busy got 1 expected 0 within 1000 cycles");
        end
        d = first_diff();
        checks++;
        if (d !== -1) begin
            errors++;
            $display("FAIL fail_bytes: at %0d got %h expected %h (count %0d vs 35)",
                     d, got[d], exp[d], got.size());
        end
        checks++;
        if (bad_widths() !== 0 || widths.size() !== 35) begin
            errors++;
            $display("FAIL fail_en_width: got %0d bad of %0d expected 0 of 35",
                     bad_widths(), widths.size());
        end
    endtask

    task automatic test_pending();
        int d;
        bit ok;
        @(negedge clk);
        LCD_STATE = 4'd1;
        repeat (2) @(negedge clk);
        wait_idle(1000, ok);
        clear_caps();
        LCD_STATE = 4'd3;
        repeat (60) @(negedge clk);
        LCD_STATE = 4'd4;
        exp_draw(4'd3, "RESULT:", "PASS");
        exp_draw(4'd4, "RESULT:", "FAIL");
        wait_idle(2000, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL pend_idle: busy got 1 expected 0 within 2000 cycles");
        end
        repeat (60) @(negedge clk);
        d = first_diff();
        checks++;
        if (d !== -1) begin
            errors++;
            $display("FAIL pend_bytes: at %0d got %h expected %h (count %0d vs 70)",
                     d, got[d], exp[d], got.size());
        end
        checks++;
        if (busy !== 1'b0 || got.size() !== 70) begin
            errors++;
            $display("FAIL pend_no_third: got busy=%b bytes=%0d expected busy=0 bytes=70",
                     busy, got.size());
        end
    endtask

    task automatic test_error_code();
        int d;
        bit ok;
        @(negedge clk);
        clear_caps();
        LCD_STATE = 4'd9;
        exp_draw(4'd9, "ERROR", "CODE 9");
        repeat (2) @(negedge clk);
        wait_idle(1000, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL err_idle: busy got 1 expected 0 within 1000 cycles");
        end
        d = first_diff();
        checks++;
        if (d !== -1) begin
            errors++;
            $display("FAIL err_bytes: at %0d got %h expected %h (count %0d vs 35)",
                     d, got[d], exp[d], got.size());
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        @(negedge clk);
        clear_caps();
        LCD_STATE = 4'd1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (got.size() >= 4 && LCD_EN) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach: got %0d bytes expected an EN pulse on byte 4", got.size());
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (LCD_EN !== 1'b0) begin
            errors++;
            $display("FAIL mid_en_drop: got %b expected 0", LCD_EN);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b expected 1", busy);
        end
        checks++;
        if (LCD_DATA !== 8'h00) begin
            errors++;
            $display("FAIL mid_data: got %h expected 00", LCD_DATA);
        end
        repeat (2) @(negedge clk);
        test_init("reinit");
    endtask

`ifdef LCD_ICID_EN
    task automatic test_icid();
        int d;
        bit ok;
        @(negedge clk);
        clear_caps();
        LCD_STATE = 4'd3;
        ic_id     = 8'h7A;
        exp_draw(4'd3, "RESULT:", "PASS");
        repeat (2) @(negedge clk);
        wait_idle(1000, ok);
        d = first_diff();
        checks++;
        if (ok !== 1'b1 || d !== -1) begin
            errors++;
            $display("FAIL icid_7a: idle=%b diff at %0d got %h expected %h",
                     ok, d, got[d], exp[d]);
        end
        @(negedge clk);
        clear_caps();
        ic_id = 8'h08;
        exp_draw(4'd3, "RESULT:", "PASS");
        repeat (2) @(negedge clk);
        wait_idle(1000, ok);
        d = first_diff();
        checks++;
        if (ok !== 1'b1 || d !== -1) begin
            errors++;
            $display("FAIL icid_08: idle=%b diff at %0d got %h expected %h",
                     ok, d, got[d], exp[d]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init("init");
        test_redraw_fail();
        test_pending();
        test_error_code();
        test_reset_mid();
`ifdef LCD_ICID_EN
        test_icid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Drives an HD44780-compatible 16x2 character LCD over an 8-bit parallel bus.
- Performs power-up initialisation, then redraws both lines whenever the 4-bit display-state code from the display-state selector changes.
- Sits between the state selector (LCD_STATE codes) and the LCD pins on the board.
- Owns all bus timing, so upstream logic only presents a state code.

Parameters:
- PWR_CYC, 750000: post-reset wait before the first command (15 ms @ 50 MHz).
- EN_CYC, 12: LCD_EN high width, in clk cycles.
- CMD_CYC, 2000: wait after each ordinary command/data write (40 us).
- CLR_CYC, 82000: wait after the clear (0x01) and home (0x02) commands (1.64 ms).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- LCD_STATE  in  4  display-state code: 1 ready, 2/5 testing, 3 pass, 4 fail, 6 invalid IC.
- LCD_DATA  out  8  LCD data bus.
- LCD_RS  out  1  0 = command, 1 = data.
- LCD_RW  out  1  tied 0 (write only).
- LCD_EN  out  1  LCD enable strobe.
- busy  out  1  high while init or redraw is in progress.

Behaviour:
- Reset values (asynchronous on reset_n=0):
  - LCD_DATA=0x00, LCD_RS=0, LCD_RW=0, LCD_EN=0, busy=1.
  - FSM in PWR_WAIT; shown-code register = 4'h0 (forces a first draw); pending=0.
- Byte-write micro-sequence, used for every byte:
  - SETUP: 1 cycle, RS/DATA driven, EN=0.
  - PULSE: EN_CYC cycles, EN=1, RS/DATA stable.
  - HOLD: EN=0, RS/DATA stable; wait CLR_CYC if the byte was command 0x01 or 0x02, else CMD_CYC.
  - RS/DATA change only in SETUP.
- Main FSM:
  - PWR_WAIT: count PWR_CYC cycles, then go to INIT.
  - INIT: commands 0x38, 0x0C, 0x06, 0x01 in order, then IDLE.
  - IDLE: busy=0. If LCD_STATE != shown code, latch LCD_STATE into the shown-code register, set busy=1, go to CLEAR. busy rises the cycle after the change is seen.
  - CLEAR: command 0x01.
  - LINE1: command 0x80, then 16 data bytes (row 0 of the latched code's message).
  - LINE2: command 0xC0, then 16 data bytes (row 1).
  - LINE2 end: if pending=1, clear pending and return to IDLE, which re-compares immediately. Otherwise go to IDLE.
- Any LCD_STATE change while busy sets pending. The code is not latched mid-draw; a redraw always shows a single consistent code.
- Character index: 4-bit counter, 0..15, wraps at the row end. Lookup is combinational ROM {code, row, index} -> ASCII, with strings space-padded to 16:
  - 1: "READY" / "INSERT IC".
  - 2, 5: "TESTING..." / "PLEASE WAIT".
  - 3: "RESULT:" / "PASS".
  - 4: "RESULT:" / "FAIL".
  - 6: "INVALID IC" / "CHECK PART".
  - 0, 7..15: "ERROR" / "CODE ?", where ? is the hex digit of the code.
- Delay counter is 20 bits and saturates at 0; parameters must fit in 20 bits.
- reset_n low mid-transfer: EN drops immediately and the full power-up sequence restarts.
- A redraw write count is exactly 35 bytes (3 commands + 32 data).

Optional Feature:
- LCD_ICID_EN defined:
  - Adds input port ic_id[7:0].
  - For codes 3, 4 and 6, row 1 characters 14..15 are replaced by upper-case ASCII hex of ic_id, latched together with the code.
  - A change of ic_id while the code is unchanged also triggers a redraw.
- LCD_ICID_EN undefined: port absent; row 1 comes entirely from the ROM.

Test Plan:
- Run with PWR_CYC=20, EN_CYC=2, CMD_CYC=5, CLR_CYC=10.
- Reset release with LCD_STATE=1: no EN pulse before cycle 20. The first four bytes are 0x38, 0x0C, 0x06, 0x01 with RS=0, then 0x01, 0x80, 'R','E','A','D','Y', 11 spaces, 0xC0, "INSERT IC" + 7 spaces. busy falls after the last HOLD.
- Idle, LCD_STATE 1 -> 4: exactly 35 EN pulses. The data bytes decode to "RESULT:" / "FAIL". EN high width is always 2 cycles.
- LCD_STATE 1 -> 3 -> 4 during the first redraw: the first redraw shows PASS (latched 3); a second redraw follows immediately showing FAIL. No third redraw.
- LCD_STATE=9: rows "ERROR" / "CODE 9".
- reset_n pulsed low mid-LINE1: EN=0 within the same cycle, busy=1, and the init sequence repeats from PWR_WAIT.
- LCD_ICID_EN defined, code 3, ic_id=0x7A: row 1 chars 14..15 = '7','A'. Changing ic_id to 0x08 triggers a redraw with '0','8'.
